rx_uart_param: RTL
==================

RX_UART_PARAM -- requirements
Module: rx_uart_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 143000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 2: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal values 1 or 2.
REQ-006 SHALL have port clk_s, input, 1 bit: single clock; all logic rises on it.
REQ-007 SHALL have port rstn_s, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port iDATA, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port oDATA, output, DATA_BITS bits: last received word, LSB first on the line.
REQ-010 SHALL have port oDONE, output, 1 bit: one-cycle pulse when a frame completes.
REQ-011 SHALL have port oPERR, output, 1 bit: parity error of the last frame.
REQ-012 SHALL have port oFERR, output, 1 bit: framing error (a stop bit was low) of the last frame.
REQ-013 SHALL have port oBUSY, output, 1 bit: high while a frame is being received.

Function
REQ-014 SHALL derive CBIT = floor(CLK_HZ/BAUD) and H = floor(CBIT/2); CBIT < 4 or an illegal parameter SHALL be a compile-time error.
REQ-015 SHALL pass iDATA through a 2-flop synchroniser (reset value 1); all decisions use the synchronised value S.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-017 SHALL, in IDLE, detect start only on a falling edge of S (previous S = 1, current S = 0); the cycle of detection is T0.
REQ-018 SHALL take sample k (k = 0 is the start bit) at cycle T0 + H + k*CBIT, using a bit-time counter sized for CBIT-1.
REQ-019 SHALL, in START, return to IDLE with no oDONE if sample 0 is 1 (glitch rejection).
REQ-020 SHALL, in DATA, shift in DATA_BITS samples LSB first.
REQ-021 SHALL skip PAR when PARITY = 0; otherwise PAR samples one bit and flags an error if the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
REQ-022 SHALL, in STOP, sample STOP_BITS bits; any low sample sets the framing flag.
REQ-023 SHALL, on the cycle after the last stop sample: return to IDLE, pulse oDONE for exactly 1 cycle, and load oDATA, oPERR and oFERR together.
REQ-024 SHALL hold oDATA, oPERR and oFERR stable until the next oDONE; frames with errors SHALL still deliver oDATA.
REQ-025 SHALL drive oBUSY high from T0+1 through the cycle oDONE is asserted, and on a false start through the rejection cycle.
REQ-026 SHALL re-arm in IDLE immediately, so back-to-back frames with no idle gap are received.
REQ-027 SHALL, after a framing error with the line still low (break), see S = 1 for at least one cycle before accepting a new start; a line held low SHALL NOT retrigger.
REQ-028 SHALL give a total latency from T0 to oDONE of H + (FRAME-1)*CBIT + 1 cycles, where FRAME = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.

Reset
REQ-029 SHALL, while rstn_s = 0, force: state to IDLE; oDATA = 0, oDONE = 0, oPERR = 0, oFERR = 0, oBUSY = 0; counters to 0; synchroniser flops to 1.
REQ-030 SHALL, if reset is asserted mid-frame, discard the partial frame and produce no oDONE; after release, the first start is accepted only per REQ-017.

Verification (CLK_HZ = 1200, BAUD = 100 -> CBIT = 12, H = 6, unless stated)
REQ-031 SHALL cover 8E1 byte 0xA5 with correct parity bit 0 -> oDONE single pulse 127 cycles after T0, oDATA = 0xA5, oPERR = 0, oFERR = 0.
REQ-032 SHALL cover 8E1 byte 0x3C with parity bit flipped, then stop bit forced low -> frame 1: oPERR = 1, oDATA = 0x3C; frame 2: oFERR = 1.
REQ-033 SHALL cover a 3-cycle low glitch on an idle line -> no oDONE, oBUSY back to 0, next valid frame received correctly.
REQ-034 SHALL cover DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, sending 0x55 then 0x2A back-to-back -> two oDONE pulses, 0x55 then 0x2A, no errors.
REQ-035 SHALL cover rstn_s pulsed low during data bit 4, followed by a full 0x81 frame -> no oDONE for the aborted frame, outputs 0 during reset, then oDATA = 0x81.
REQ-036 SHALL cover a line held low for 3 frame times, then released and sent 0x12 -> exactly one oDONE with oFERR = 1 and oDATA = 0x00, then one oDONE with oDATA = 0x12 and no error flags.

Source files
------------

// File: rtl/rx_uart_param.sv
// Parameterised UART receiver: 2-flop synchroniser, mid-bit sampling,
// optional parity, 1 or 2 checked stop bits, one-cycle done pulse.
module rx_uart_param #(
  parameter int CLK_HZ    = 143000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 2,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_s,
  input  logic                 rstn_s,
  input  logic                 iDATA,
  output logic [DATA_BITS-1:0] oDATA,
  output logic                 oDONE,
  output logic                 oPERR,
  output logic                 oFERR,
  output logic                 oBUSY
);

  localparam int CBIT = CLK_HZ / BAUD;
  localparam int H    = CBIT / 2;
  localparam int CW   = (CBIT < 4) ? 2 : $clog2(CBIT);

  localparam logic [CW-1:0] H_M1  = CW'(H - 1);
  localparam logic [CW-1:0] CB_M1 = CW'(CBIT - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [3:0]    LST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LST_S = 4'(STOP_BITS - 1);
  localparam logic          ODD   = (PARITY == 1);

  if (CBIT < 4) begin : g_bad_cbit
    $error("rx_uart_param: CLK_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("rx_uart_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("rx_uart_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("rx_uart_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state_q, state_d;

  logic                 sync_q, s_q, sp_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 operr_q, operr_d;
  logic                 oferr_q, oferr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // only a true 1->0 edge arms, so a held-low line never retriggers
        if (sp_q && !s_q) begin
          state_d = START;
          cnt_d   = H_M1;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - C_ONE;
        end else if (s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = DATA;
          cnt_d   = CB_M1;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - C_ONE;
        end else begin
          cnt_d = CB_M1;
          sh_d  = {s_q, sh_q[DATA_BITS-1:1]};
          if (bit_q == LST_D) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (!tick) begin
          cnt_d = cnt_q - C_ONE;
        end else begin
          cnt_d   = CB_M1;
          perr_d  = (^sh_q) ^ s_q ^ ODD;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - C_ONE;
        end else if (bit_q == LST_S) begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          done_d  = 1'b1;
          data_d  = sh_q;
          operr_d = perr_q;
          oferr_d = ferr_q | ~s_q;
        end else begin
          cnt_d  = CB_M1;
          ferr_d = ferr_q | ~s_q;
          bit_d  = bit_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      sync_q  <= 1'b1;
      s_q     <= 1'b1;
      sp_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= iDATA;
      s_q     <= sync_q;
      sp_q    <= s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign oDATA = data_q;
  assign oDONE = done_q;
  assign oPERR = operr_q;
  assign oFERR = oferr_q;
  assign oBUSY = busy_q;

endmodule
